pcie_ss_ctrl_arb: RTL

Arbitrates and sequences access to the PCIe subsystem sideband control port (`o_ss_ctrl_cmd` / `o_ss_ctrl_addr` / `o_ss_ctrl_writedata`, `i_ss_readdata` / `i_ss_ack`) for several requesters. Typical requesters are the software path from the PCIe CSR block and a hardware link-init sequencer. Each requester gets a one-entry request buffer. Pending requests are granted round-robin, and each is run as one command/ack transaction with a completion timeout.

---
 rtl/pcie_ss_ctrl_arb.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/pcie_ss_ctrl_arb.sv
// Round-robin arbiter and sequencer for the PCIe subsystem sideband control port.
// Each requester has a one-entry buffer, and each grant runs as one command/ack transaction with a completion timeout.
module pcie_ss_ctrl_arb #(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      i_req_valid,
  output logic [NUM_REQ-1:0]      o_req_ready,
  input  logic [2*NUM_REQ-1:0]    i_req_cmd,
  input  logic [18*NUM_REQ-1:0]   i_req_addr,
  input  logic [32*NUM_REQ-1:0]   i_req_wdata,
  output logic [NUM_REQ-1:0]      o_req_done,
  output logic                    o_req_err,
  output logic [31:0]             o_req_rdata,
  output logic [1:0]              o_ss_ctrl_cmd,
  output logic [17:0]             o_ss_ctrl_addr,
  output logic [31:0]             o_ss_ctrl_writedata,
  input  logic [31:0]             i_ss_readdata,
  input  logic                    i_ss_ack,
  output logic                    o_busy,
  output logic [15:0]             o_timeout_cnt
);

  localparam int          RW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [RW:0] NUM_REQ_W = (RW+1)'(NUM_REQ);
  localparam logic [31:0] TMO_LAST  = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0]  CMD_IDLE  = 2'b00;
  localparam logic [1:0]  CMD_WR    = 2'b01;
  localparam logic [1:0]  CMD_RD    = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_GAP  = 2'b10
  } state_t;

  state_t               state_r;
  logic [NUM_REQ-1:0]   pending_r;
  logic [NUM_REQ-1:0]   ready_r;
  logic [NUM_REQ-1:0]   done_r;
  logic                 err_r;
  logic [31:0]          rdata_r;
  logic [1:0]           ss_cmd_r;
  logic [17:0]          ss_addr_r;
  logic [31:0]          ss_wdata_r;
  logic                 busy_r;
  logic [15:0]          tocnt_r;
  logic [31:0]          timer_r;
  logic [RW-1:0]        rr_r;
  logic [RW-1:0]        grant_r;
  logic [1:0]           slot_cmd_r   [NUM_REQ];
  logic [17:0]          slot_addr_r  [NUM_REQ];
  logic [31:0]          slot_wdata_r [NUM_REQ];

  logic                 found_s;
  logic [RW-1:0]        pick_s;
  logic [NUM_REQ-1:0]   pending_nxt_s;

  function automatic logic [RW-1:0] rr_idx(input logic [RW-1:0] base, input int off);
    logic [RW:0] sum;
    sum = {1'b0, base} + off[RW:0];
    if (sum >= NUM_REQ_W) begin
      sum = sum - NUM_REQ_W;
    end else begin
      sum = sum;
    end
    return sum[RW-1:0];
  endfunction

  function automatic logic cmd_legal(input logic [1:0] c);
    case (c)
      CMD_WR, CMD_RD: return 1'b1;
      default:        return 1'b0;
    endcase
  endfunction

  // Round-robin search: first pending slot at or after rr, in modulo order.
  always_comb begin
    found_s = 1'b0;
    pick_s  = {RW{1'b0}};
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found_s && pending_r[rr_idx(rr_r, k)]) begin
        found_s = 1'b1;
        pick_s  = rr_idx(rr_r, k);
      end else begin
        found_s = found_s;
      end
    end
  end

  // Next pending vector: set on acceptance, cleared for the granted slot at the end of GAP.
  always_comb begin
    pending_nxt_s = pending_r;
    for (int i = 0; i < NUM_REQ; i++) begin
      pending_nxt_s[i] = (pending_r[i] | (i_req_valid[i] & ready_r[i])) &
                         ~((state_r == ST_GAP) && (grant_r == RW'(i)));
    end
  end

  // Request buffers, arbitration pointer and the transaction FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      pending_r  <= {NUM_REQ{1'b0}};
      ready_r    <= {NUM_REQ{1'b1}};
      done_r     <= {NUM_REQ{1'b0}};
      err_r      <= 1'b0;
      rdata_r    <= 32'h0000_0000;
      ss_cmd_r   <= CMD_IDLE;
      ss_addr_r  <= 18'h0_0000;
      ss_wdata_r <= 32'h0000_0000;
      busy_r     <= 1'b0;
      tocnt_r    <= 16'h0000;
      timer_r    <= 32'h0000_0000;
      rr_r       <= {RW{1'b0}};
      grant_r    <= {RW{1'b0}};
      for (int i = 0; i < NUM_REQ; i++) begin
        slot_cmd_r[i]   <= 2'b00;
        slot_addr_r[i]  <= 18'h0_0000;
        slot_wdata_r[i] <= 32'h0000_0000;
      end
    end else begin
      pending_r <= pending_nxt_s;
      ready_r   <= ~pending_nxt_s;
      done_r    <= {NUM_REQ{1'b0}};
      for (int i = 0; i < NUM_REQ; i++) begin
        if (i_req_valid[i] && ready_r[i]) begin
          slot_cmd_r[i]   <= i_req_cmd[2*i +: 2];
          slot_addr_r[i]  <= i_req_addr[18*i +: 18];
          slot_wdata_r[i] <= i_req_wdata[32*i +: 32];
        end
      end
      case (state_r)
        ST_IDLE: begin
          if (found_s) begin
            grant_r <= pick_s;
            rr_r    <= rr_idx(pick_s, 32'sd1);
            busy_r  <= 1'b1;
            if (cmd_legal(slot_cmd_r[pick_s])) begin
              ss_cmd_r   <= slot_cmd_r[pick_s];
              ss_addr_r  <= slot_addr_r[pick_s];
              ss_wdata_r <= slot_wdata_r[pick_s];
              timer_r    <= 32'h0000_0000;
              state_r    <= ST_BUSY;
            end else begin
              // Illegal command completes with an error and never reaches the bus.
              err_r          <= 1'b1;
              rdata_r        <= 32'h0000_0000;
              done_r[pick_s] <= 1'b1;
              state_r        <= ST_GAP;
            end
          end
        end
        ST_BUSY: begin
          if (i_ss_ack) begin
            rdata_r         <= (ss_cmd_r == CMD_RD) ? i_ss_readdata : 32'h0000_0000;
            err_r           <= 1'b0;
            done_r[grant_r] <= 1'b1;
            ss_cmd_r        <= CMD_IDLE;
            state_r         <= ST_GAP;
          end else if (timer_r == TMO_LAST) begin
            rdata_r         <= 32'hFFFF_FFFF;
            err_r           <= 1'b1;
            done_r[grant_r] <= 1'b1;
            ss_cmd_r        <= CMD_IDLE;
            state_r         <= ST_GAP;
            if (tocnt_r != 16'hFFFF) begin
              tocnt_r <= tocnt_r + 16'd1;
            end
          end else begin
            timer_r <= timer_r + 32'd1;
          end
        end
        ST_GAP: begin
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          ss_cmd_r <= CMD_IDLE;
          busy_r   <= 1'b0;
          state_r  <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_req_ready         = ready_r;
  assign o_req_done          = done_r;
  assign o_req_err           = err_r;
  assign o_req_rdata         = rdata_r;
  assign o_ss_ctrl_cmd       = ss_cmd_r;
  assign o_ss_ctrl_addr      = ss_addr_r;
  assign o_ss_ctrl_writedata = ss_wdata_r;
  assign o_busy              = busy_r;
  assign o_timeout_cnt       = tocnt_r;

endmodule
